// File: rtl/mfdfa_sequencer.sv
// Top-level MFDFA phase sequencer: mean -> profile -> per-scale chunk/detrend -> per-scale log.
// All outputs are registered; each unit handshake waits as long as needed for its done pulse.
module mfdfa_sequencer #(
    parameter int N_SAMPLES = 301,
    parameter int ADDR_W    = 9,
    parameter int MIN_SCALE = 16,
    parameter int N_SCALES  = 4,
    parameter int SIDX_W    = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mean_clr,
    output logic              mean_acc_en,
    output logic              div_start,
    input  logic              div_done,
    output logic              prof_wr_en,
    output logic [ADDR_W-1:0] prof_addr,
    output logic              seg_start,
    output logic [ADDR_W-1:0] seg_base,
    output logic [ADDR_W:0]   seg_len,
    input  logic              seg_done,
    output logic              log_start,
    output logic [SIDX_W-1:0] log_scale_idx,
    output logic [ADDR_W-1:0] log_seg_count,
    input  logic              log_done
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_MEAN      = 4'd1;
    localparam logic [3:0] S_MEAN_TAIL = 4'd2;
    localparam logic [3:0] S_DIV_WAIT  = 4'd3;
    localparam logic [3:0] S_PROF      = 4'd4;
    localparam logic [3:0] S_PROF_TAIL = 4'd5;
    localparam logic [3:0] S_EVAL      = 4'd6;
    localparam logic [3:0] S_SEG_WAIT  = 4'd7;
    localparam logic [3:0] S_LOG_WAIT  = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_MEAN  = 3'd1;
    localparam logic [2:0] PH_PROF  = 3'd2;
    localparam logic [2:0] PH_CHUNK = 3'd3;
    localparam logic [2:0] PH_LOG   = 3'd4;
    localparam logic [2:0] PH_DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ADDR_W+1:0] N_EXT     = (ADDR_W+2)'(N_SAMPLES);
    localparam logic [ADDR_W+1:0] MIN_EXT   = (ADDR_W+2)'(MIN_SCALE);
    localparam logic [SIDX_W-1:0] LAST_K    = SIDX_W'(N_SCALES - 1);

    logic [3:0]        state;
    logic [SIDX_W-1:0] k;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W+1:0] scale;
    logic [ADDR_W+1:0] seg_end;

    // Two extra bits keep base+scale from wrapping even for scales beyond the buffer.
    assign scale   = MIN_EXT << k;
    assign seg_end = {2'b00, base} + scale;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            phase         <= PH_IDLE;
            mem_rd_en     <= 1'b0;
            mem_addr      <= '0;
            mean_clr      <= 1'b0;
            mean_acc_en   <= 1'b0;
            div_start     <= 1'b0;
            prof_wr_en    <= 1'b0;
            prof_addr     <= '0;
            seg_start     <= 1'b0;
            seg_base      <= '0;
            seg_len       <= '0;
            log_start     <= 1'b0;
            log_scale_idx <= '0;
            log_seg_count <= '0;
            k             <= '0;
            base          <= '0;
            count         <= '0;
        end else begin
            mean_clr    <= 1'b0;
            div_start   <= 1'b0;
            seg_start   <= 1'b0;
            log_start   <= 1'b0;
            done        <= 1'b0;
            mean_acc_en <= mem_rd_en && (state == S_MEAN);
            prof_wr_en  <= mem_rd_en && (state == S_PROF);
            prof_addr   <= mem_addr;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_MEAN;
                        busy      <= 1'b1;
                        phase     <= PH_MEAN;
                        mean_clr  <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end
                end
                S_MEAN, S_PROF: begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        state     <= (state == S_MEAN) ? S_MEAN_TAIL : S_PROF_TAIL;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                S_MEAN_TAIL: begin
                    div_start <= 1'b1;
                    state     <= S_DIV_WAIT;
                end
                S_DIV_WAIT: begin
                    // A done coincident with its own start pulse is not a real completion.
                    if (div_done && !div_start) begin
                        state     <= S_PROF;
                        phase     <= PH_PROF;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end
                end
                S_PROF_TAIL: begin
                    state <= S_EVAL;
                    phase <= PH_CHUNK;
                    k     <= '0;
                    base  <= '0;
                    count <= '0;
                end
                S_EVAL: begin
                    if (seg_end <= N_EXT) begin
                        seg_start <= 1'b1;
                        seg_base  <= base;
                        seg_len   <= scale[ADDR_W:0];
                        state     <= S_SEG_WAIT;
                    end else if (count != '0) begin
                        log_start     <= 1'b1;
                        log_scale_idx <= k;
                        log_seg_count <= count;
                        phase         <= PH_LOG;
                        state         <= S_LOG_WAIT;
                    end else if (k == LAST_K) begin
                        done  <= 1'b1;
                        phase <= PH_DONE;
                        state <= S_DONE;
                    end else begin
                        k <= k + SIDX_W'(1);
                    end
                end
                S_SEG_WAIT: begin
                    if (seg_done && !seg_start) begin
                        base  <= base + scale[ADDR_W-1:0];
                        count <= count + ADDR_W'(1);
                        state <= S_EVAL;
                    end
                end
                S_LOG_WAIT: begin
                    if (log_done && !log_start) begin
                        if (k == LAST_K) begin
                            done  <= 1'b1;
                            phase <= PH_DONE;
                            state <= S_DONE;
                        end else begin
                            k     <= k + SIDX_W'(1);
                            base  <= '0;
                            count <= '0;
                            phase <= PH_CHUNK;
                            state <= S_EVAL;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    phase <= PH_IDLE;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    phase <= PH_IDLE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mfdfa_sequencer.md
Name: mfdfa_sequencer

Overview:
- Top-level controller for the MFDFA datapath.
- Steps the analysis through its fixed phases: mean calculation, profile construction, chunking/detrending per scale, and log-results per scale.
- Owns the sample-memory read port and the start/done handshakes to the mean divider, the segment detrend unit and the log/fluctuation unit.
- Sits between the host start/done interface and those datapath units.

Parameters:
- N_SAMPLES, 301, number of samples in the price buffer.
- ADDR_W, 9, width of sample/profile addresses and segment fields.
- MIN_SCALE, 16, first segment length; scale k is MIN_SCALE << k.
- N_SCALES, 4, number of scales processed.
- SIDX_W, 3, width of the scale index.

Ports:
- Clk  in  1  single system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  request one full analysis run; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse at end of run.
- phase  out  3  0 IDLE, 1 MEAN, 2 PROFILE, 3 CHUNK, 4 LOG, 5 DONE.
- mem_rd_en  out  1  sample memory read strobe (memory has 1-cycle read latency).
- mem_addr  out  ADDR_W  sample read address.
- mean_clr  out  1  one-cycle pulse clearing the mean accumulator.
- mean_acc_en  out  1  accumulate the returned sample; equals mem_rd_en delayed 1 cycle during MEAN.
- div_start  out  1  one-cycle pulse starting mean division.
- div_done  in  1  divider completion pulse.
- prof_wr_en  out  1  write cumulative profile value; equals mem_rd_en delayed 1 cycle during PROFILE.
- prof_addr  out  ADDR_W  mem_addr delayed 1 cycle.
- seg_start  out  1  one-cycle pulse starting a detrend of one segment.
- seg_base  out  ADDR_W  first profile index of the segment; held until seg_done.
- seg_len  out  ADDR_W+1  current scale; held until seg_done.
- seg_done  in  1  detrend completion pulse.
- log_start  out  1  one-cycle pulse requesting the log/fluctuation result for the current scale.
- log_scale_idx  out  SIDX_W  current scale index k.
- log_seg_count  out  ADDR_W  number of segments processed at scale k.
- log_done  in  1  log unit completion pulse.

Behaviour:
- Reset: state IDLE; every output 0; all counters 0.
- IDLE:
  - start=1 → next cycle enters MEAN, with mean_clr=1 that cycle and busy=1.
- MEAN:
  - mem_rd_en=1 for exactly N_SAMPLES consecutive cycles, mem_addr 0..N_SAMPLES-1.
  - mean_acc_en follows 1 cycle later.
  - The cycle after the final mean_acc_en: div_start=1 (single cycle).
  - Then wait for div_done. div_done is sampled only from the cycle after div_start.
- PROFILE:
  - The cycle after div_done, sweep addresses again for N_SAMPLES cycles.
  - prof_wr_en and prof_addr lag mem_rd_en and mem_addr by 1 cycle.
  - The CHUNK phase begins the cycle after the final prof_wr_en.
- CHUNK, per scale k:
  - scale = MIN_SCALE << k; base starts at 0 and count at 0.
  - If base+scale <= N_SAMPLES: assert seg_start for one cycle with seg_base=base and seg_len=scale, then wait for seg_done. On seg_done: base += scale, count++, and re-evaluate next cycle.
  - Otherwise go to LOG. The comparison is done at ADDR_W+2 bits, so there is no wrap.
  - If count==0 for a scale (scale > N_SAMPLES), skip LOG for that scale and advance k.
- LOG:
  - log_start pulses 1 cycle with log_scale_idx=k and log_seg_count=count; then wait for log_done.
  - On log_done: if k==N_SCALES-1 go to DONE, else k++ and return to CHUNK.
- DONE:
  - done=1 and phase=5 for 1 cycle; next cycle IDLE with busy=0.
- Ignored inputs:
  - start while busy is ignored. start in the DONE cycle is also ignored.
  - seg_done, div_done and log_done outside their respective wait states are ignored.
  - A done input arriving in the same cycle as its start pulse is ignored.
- Reset mid-operation: the next edge returns to the IDLE/reset values. Late done pulses after reset are ignored.
- Strobe timing: all outputs are registered. start and done strobes are never asserted for more than one cycle.

Test Plan:
- Defaults, start pulse, div/seg/log done returned 3 cycles after each request → exactly 301 mem_rd_en (addr 0..300) and 301 mean_acc_en; one div_start; 301 prof_wr_en; 33 seg_start pulses (18/9/4/2 per scale, seg_len 16/32/64/128); 4 log_start with log_seg_count 18,9,4,2; one done pulse; phase sequence 0,1,2,3,4,…,5,0.
- Segment fields check → at scale 0, seg_base = 0,16,…,272 and the last segment ends at 287 ≤ 301; no seg_start with base+len > 301.
- N_SCALES=6 override → scale 4 (256) gives 1 segment and log_seg_count=1; scale 5 (512) gives 0 segments, no log_start for idx 5, and done still follows.
- Spurious inputs: seg_done/log_done pulses in IDLE and during MEAN, start pulses while busy → no state change, no extra pulses, and the pulse counts from the first scenario are unchanged.
- Rst asserted for 1 cycle mid-CHUNK (after 5 segments), then a delayed seg_done → all outputs 0, phase 0; a new start replays the full sequence from addr 0.
- div_done held high continuously from before div_start → the PROFILE sweep begins exactly 2 cycles after the div_start cycle, never in the same cycle as div_start.
